// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, default datapath geometry and saturation limits.
package alu_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int unsigned DEF_WIDTH = 64;
   localparam int unsigned DEF_CHUNK = 16;

   // Widest result the saturation helpers can describe; callers truncate to their WIDTH.
   localparam int unsigned SAT_MAX_W = 1024;

   // Largest signed value in w bits: 0 followed by w-1 ones.
   function automatic logic [SAT_MAX_W-1:0] sat_max(input int unsigned w);
      return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
   endfunction

   // Most negative signed value in w bits: 1 followed by w-1 zeros.
   function automatic logic [SAT_MAX_W-1:0] sat_min(input int unsigned w);
      return SAT_MAX_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit slice of the add/sub carry chain; purely combinational.
module addsub_chunk #(
   parameter int unsigned CHUNK = 16
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum_c,
   output logic             cout_c,
   output logic             cmsb_c,
   output logic             zero_c
);

   logic [CHUNK:0] full_c;

   assign full_c = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);
   assign sum_c  = full_c[CHUNK-1:0];
   assign cout_c = full_c[CHUNK];
   // Carry into the top bit falls out of the top-bit sum identity.
   assign cmsb_c = a[CHUNK-1] ^ b[CHUNK-1] ^ full_c[CHUNK-1];
   assign zero_c = ~|full_c[CHUNK-1:0];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract, one CHUNK-bit carry slice per stage, valid/ready on both sides.
// Define ADDSUB_SAT_EN to clamp signed overflow at the final stage.
module pipe_addsub
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned CHUNK  = DEF_CHUNK,
   parameter int unsigned STAGES = WIDTH / CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned LAST = STAGES - 1;

   logic adv_c;
   logic ovf_q;

   // Whole pipeline moves together unless a finished result is waiting.
   assign adv_c    = ~out_valid | out_ready;
   assign in_ready = adv_c;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int unsigned LO = k * CHUNK;

      logic             v_q;
      logic             c_q;
      logic             z_q;
      logic [WIDTH-1:0] acc_q;
      logic [WIDTH-1:0] bx_q;

      logic             vin_c;
      logic             cin_c;
      logic             zin_c;
      logic [WIDTH-1:0] base_c;
      logic [WIDTH-1:0] bsrc_c;
      logic [WIDTH-1:0] acc_c;
      logic [WIDTH-1:0] accfin_c;
      logic [CHUNK-1:0] s_c;
      logic             co_c;
      logic             cm_c;
      logic             zc_c;
      logic             ovf_c;
      logic             zfin_c;

      // acc holds finished sum chunks below LO and untouched a chunks above;
      // bx holds the (inverted for subtract) b chunks still to come, next one at bit 0.
      if (k == 0) begin : g_head
         assign vin_c  = in_valid;
         assign base_c = a;
         assign bsrc_c = (sel == OP_SUB) ? ~b : b;
         assign cin_c  = sel;
         assign zin_c  = 1'b1;
      end else begin : g_body
         assign vin_c  = g_stg[k-1].v_q;
         assign base_c = g_stg[k-1].acc_q;
         assign bsrc_c = g_stg[k-1].bx_q;
         assign cin_c  = g_stg[k-1].c_q;
         assign zin_c  = g_stg[k-1].z_q;
      end

      addsub_chunk #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a      (base_c[LO +: CHUNK]),
         .b      (bsrc_c[CHUNK-1:0]),
         .cin    (cin_c),
         .sum_c  (s_c),
         .cout_c (co_c),
         .cmsb_c (cm_c),
         .zero_c (zc_c)
      );

      assign ovf_c = cm_c ^ co_c;

      always_comb begin
         acc_c               = base_c;
         acc_c[LO +: CHUNK]  = s_c;
      end

      if (k == LAST) begin : g_tail
`ifdef ADDSUB_SAT_EN
         // Clamp toward the sign of a; both operands share that sign whenever ovf is set.
         always_comb begin
            accfin_c = acc_c;
            zfin_c   = zin_c & zc_c;
            if (ovf_c) begin
               accfin_c = base_c[WIDTH-1] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH));
               zfin_c   = 1'b0;
            end
         end
`else
         assign accfin_c = acc_c;
         assign zfin_c   = zin_c & zc_c;
`endif
      end else begin : g_pass
         assign accfin_c = acc_c;
         assign zfin_c   = zin_c & zc_c;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            acc_q <= '0;
         end else if (adv_c) begin
            v_q   <= vin_c;
            c_q   <= co_c;
            z_q   <= zfin_c;
            acc_q <= accfin_c;
         end
      end

      always_ff @(posedge clk) begin
         if (adv_c) begin
            bx_q <= bsrc_c >> CHUNK;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (adv_c) begin
         ovf_q <= g_stg[LAST].ovf_c;
      end
   end

   assign out_valid = g_stg[LAST].v_q;
   assign res       = g_stg[LAST].acc_q;
   assign cout      = g_stg[LAST].c_q;
   assign zero      = g_stg[LAST].z_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed-vector bench for pipe_addsub at WIDTH=64, CHUNK=16 (four stages).
module tb_pipe_addsub;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic        sel;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] res;
   logic        cout;
   logic        ovf;
   logic        zero;

`ifdef ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        sel;
      logic [63:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
   } vec_t;

   typedef struct {
      logic [63:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
   } out_t;

   vec_t tv[12];
   out_t outq[$];
   int   out_cyc[$];
   int   acc_cyc[$];
   int   cyc;
   int   total;
   int   bad;

   pipe_addsub #(
      .WIDTH (64),
      .CHUNK (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record handshakes half a cycle before the edge that completes them.
   always @(negedge clk) begin
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
         outq.push_back('{res: res, cout: cout, ovf: ovf, zero: zero});
         out_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cmp_out(input string tag, input out_t o, input vec_t v);
      chk({tag, ".res"},  o.res,         v.res);
      chk({tag, ".cout"}, 64'(o.cout),   64'(v.cout));
      chk({tag, ".ovf"},  64'(o.ovf),    64'(v.ovf));
      chk({tag, ".zero"}, 64'(o.zero),   64'(v.zero));
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input vec_t v);
      int n;
      n = 0;
      a = v.a; b = v.b; sel = v.sel; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_outs(input string tag, input int n);
      int t;
      t = 0;
      while (outq.size() < n && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk({tag, ".count"}, 64'(outq.size()), 64'(n));
   endtask

   task automatic clear_logs();
      outq.delete();
      out_cyc.delete();
      acc_cyc.delete();
   endtask

   function automatic vec_t mk(input logic [63:0] ia, input logic [63:0] ib, input logic isel,
                               input logic [63:0] r, input logic c, input logic o, input logic z);
      vec_t v;
      v.a = ia; v.b = ib; v.sel = isel; v.res = r; v.cout = c; v.ovf = o; v.zero = z;
      return v;
   endfunction

   initial begin
      cyc = 0; total = 0; bad = 0;
      tv[0]  = mk(64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0, 1'b0);
      tv[1]  = mk(64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0, 1'b0);
      tv[2]  = mk(64'hFFFF, 64'd1, 1'b0, 64'h10000, 1'b0, 1'b0, 1'b0);
      tv[3]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
      tv[4]  = mk(64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
      tv[5]  = mk(64'h8000_0000_0000_0000, 64'd1, 1'b1,
                  SAT ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
      tv[6]  = mk(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
      tv[7]  = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                  SAT ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
      tv[8]  = mk(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
      tv[9]  = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                  SAT ? 64'h8000_0000_0000_0000 : 64'd0, 1'b1, 1'b1, SAT ? 1'b0 : 1'b1);
      tv[10] = mk(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
                  64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0);
      tv[11] = mk(64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sel = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.res",       res,            64'd0);
      chk("rst.cout",      64'(cout),      64'd0);
      chk("rst.ovf",       64'(ovf),       64'd0);
      chk("rst.zero",      64'(zero),      64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Latency and throughput: three back-to-back adds.
      clear_logs();
      for (int i = 0; i < 3; i++) send(tv[i]);
      wait_outs("lat", 3);
      for (int i = 0; i < 3 && i < outq.size(); i++) begin
         cmp_out($sformatf("lat%0d", i), outq[i], tv[i]);
         chk($sformatf("lat%0d.cycle", i), 64'(out_cyc[i] - acc_cyc[0]), 64'(4 + i));
      end

      // Whole table streamed back-to-back.
      clear_logs();
      for (int i = 0; i < 12; i++) send(tv[i]);
      wait_outs("tbl", 12);
      for (int i = 0; i < 12 && i < outq.size(); i++) cmp_out($sformatf("tbl%0d", i), outq[i], tv[i]);

      // Back-pressure: output stalled while six ops are offered.
      clear_logs();
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(tv[i + 3]);
         end
         begin
            repeat (8) begin
               @(negedge clk);
               if (out_valid) begin
                  chk("bp.in_ready", 64'(in_ready), 64'd0);
                  chk("bp.held_res", res, tv[3].res);
                  chk("bp.held_zero", 64'(zero), 64'(tv[3].zero));
               end
            end
            chk("bp.stalled_valid", 64'(out_valid), 64'd1);
            chk("bp.no_drain", 64'(outq.size()), 64'd0);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      wait_outs("bp", 6);
      for (int i = 0; i < 6 && i < outq.size(); i++) cmp_out($sformatf("bp%0d", i), outq[i], tv[i + 3]);

      // Bubbles: valid pattern 1,0,1,0 reappears four cycles later.
      clear_logs();
      send(tv[1]);
      idle(1);
      send(tv[10]);
      idle(1);
      wait_outs("bub", 2);
      if (outq.size() == 2) begin
         cmp_out("bub0", outq[0], tv[1]);
         cmp_out("bub1", outq[1], tv[10]);
         chk("bub0.cycle", 64'(out_cyc[0] - acc_cyc[0]), 64'd4);
         chk("bub1.cycle", 64'(out_cyc[1] - acc_cyc[0]), 64'd6);
      end
      idle(4);

      // Reset with three ops in flight: nothing may emerge afterwards.
      clear_logs();
      for (int i = 0; i < 3; i++) send(tv[i + 4]);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst.out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst.res",       res,            64'd0);
      chk("mid_rst.in_ready",  64'(in_ready),  64'd1);
      repeat (10) @(negedge clk);
      chk("mid_rst.no_stale",  64'(outq.size()), 64'd0);
      chk("mid_rst.valid_low", 64'(out_valid),   64'd0);

      // Pipeline still usable after the mid-stream reset.
      @(posedge clk); #1;
      clear_logs();
      send(tv[6]);
      wait_outs("post_rst", 1);
      if (outq.size() == 1) cmp_out("post_rst", outq[0], tv[6]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined two's-complement add/subtract unit. It is the next generation of the combinational 64-bit ripple add/sub in the ALU.
- The carry chain is split into CHUNK-bit slices, with one slice per pipeline stage, so WIDTH can scale without a long combinational ripple.
- Valid/ready handshake on input and output, with full back-pressure.
- Adds carry, signed-overflow and zero flags. Feeds the ALU result mux and the address-generation path.

Parameters:
- WIDTH, 64, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 16, bits resolved per pipeline stage; CHUNK == WIDTH gives a single stage.
- STAGES, WIDTH/CHUNK, derived pipeline depth; not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  unit accepts an operation this cycle.
- a  in  WIDTH  operand 1.
- b  in  WIDTH  operand 2.
- sel  in  1  0 = add (a+b), 1 = subtract (a-b).
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- res  out  WIDTH  result.
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  res == 0.

Behaviour:
- Reset (rst high at a clock edge):
  - All stage valid bits clear; out_valid=0, res=0, cout=0, ovf=0, zero=0.
  - In-flight operations are discarded, including when reset arrives mid-pipeline.
  - in_ready=1 in the cycle after reset deasserts.
- Global enable: adv = ~out_valid | out_ready; in_ready = adv (combinational).
- Advance rule:
  - When adv=1: stage valid v[0] <= in_valid, and v[k] <= v[k-1].
  - When adv=0: no register changes.
  - Bubbles propagate normally.
- Accept rule: an operation is accepted only when in_valid & in_ready.
  - On acceptance, stage 0 captures a, b, sel.
  - Upper operand chunks are carried forward in skew registers, so chunk k is consumed at stage k.
- Stage k datapath:
  - Adds a chunk k and (sel ? ~b chunk k : b chunk k), with carry-in from the stage k-1 carry register.
  - Stage 0 carry-in = sel.
  - Registers the sum chunk, the carry out, and a running zero-AND.
- Latency:
  - Exactly STAGES cycles from acceptance to out_valid, when there are no stalls.
  - Throughput is one operation per cycle.
- Output stability: while out_valid & ~out_ready, res/cout/ovf/zero hold stable and the whole pipeline freezes.
- Simultaneous events:
  - Output drain and new input in the same cycle are both accepted (adv=1).
  - Output order equals input order; no reordering.
- Arithmetic rules:
  - Modular in WIDTH bits.
  - ovf is computed at the final stage from the MSB-chunk carries.
  - zero is the AND of per-chunk zero tests.
  - Flag values are undefined while out_valid=0, but are held at the last value in practice.
- Boundary cases:
  - WIDTH == CHUNK: one stage, latency 1.
  - Subtract of equal operands: res=0, zero=1, cout=1.
  - All-ones + 1: res=0, cout=1, zero=1, ovf=0.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: signed saturation at the final stage, adding no latency.
  - If ovf=1, res is clamped to 0 followed by WIDTH-1 ones when a[MSB]=0, or 1 followed by WIDTH-1 zeros when a[MSB]=1.
  - ovf still reports the overflow.
  - zero=0 whenever the result is clamped.
  - cout is unaffected.
- Undefined: results wrap modulo 2^WIDTH; no clamp logic is present.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings OP_ADD=1'b0 and OP_SUB=1'b1;
  - default WIDTH=64 and CHUNK=16;
  - the saturation limit constants as functions of WIDTH.
- One sub-module, addsub_chunk: a CHUNK-bit combinational add with carry-in, returning sum, carry out, carry into MSB, and a zero flag. It is instantiated STAGES times inside a generate loop; the pipeline registers live in pipe_addsub.

Test Plan (WIDTH=64, CHUNK=16, STAGES=4):
- Reset mid-stream: issue 3 ops, assert rst for 1 cycle -> out_valid stays 0, res=0, and no stale result ever emerges.
- Latency and throughput: back-to-back adds 1+2, 5+7, 0xFFFF+1 with out_ready=1 -> out_valid in cycles 4, 5, 6 (counted from the first acceptance) with res = 3, 12, 0x10000; carry crosses chunk 0 to chunk 1.
- Full carry ripple: a=0xFFFFFFFFFFFFFFFF, b=1, sel=0 -> res=0, cout=1, zero=1, ovf=0.
- Subtract and overflow:
  - 5-7 -> res=0xFFFFFFFFFFFFFFFE, cout=0.
  - 0x8000000000000000-1 -> res=0x7FFFFFFFFFFFFFFF, ovf=1.
  - Under ADDSUB_SAT_EN the second case gives res=0x8000000000000000, ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles with 6 ops offered -> in_ready drops once the output is occupied, res is held stable, and all 6 results emerge in order after release.
- Bubbles: in_valid toggles 1,0,1,0 -> out_valid follows the same pattern delayed by 4 cycles.
